// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance, stall, jump/branch load and a circular return-address stack.
// Define PC_UNIT_ALIGN_CHECK_EN to reject loads whose target is not a multiple of STEP (adds misalign output).
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
`ifdef PC_UNIT_ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  localparam int unsigned      PW      = $clog2(RAS_DEPTH);
  localparam int unsigned      CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_idx;
  logic             push;
  logic             load_ok;
  logic             full;

`ifdef PC_UNIT_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  logic mis_q, mis_d;
  assign load_ok  = (load_addr & ALIGN_MASK) == '0;
  assign misalign = mis_q;
`else
  assign load_ok = 1'b1;
`endif

  assign pc_seq    = pc_q + STEP_W;
  assign top_idx   = ptr_q - PW'(1);
  assign full      = (cnt_q == DEPTH_C);
  assign pc_out    = pc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
`ifdef PC_UNIT_ALIGN_CHECK_EN
    mis_d = mis_q;
`endif
    if (!stall) begin
      if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[top_idx];
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d  = pc_seq;
          unf_d = 1'b1;
        end
      end else if (load) begin
        if (load_ok) begin
          pc_d = load_addr;
          if (call) begin
            // Push on full overwrites the oldest slot; pointer is circular.
            push  = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CW'(1);
          end
        end else begin
`ifdef PC_UNIT_ALIGN_CHECK_EN
          mis_d = 1'b1;
`endif
        end
      end else if (en) begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef PC_UNIT_ALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef PC_UNIT_ALIGN_CHECK_EN
      mis_q <= mis_d;
`endif
    end
  end

  // Entry storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_seq;
  end

endmodule
